// File: rtl/cdc_clear_sequencer.sv
// Sequences a clear of a clearable CDC source: drains the in-flight transfer,
// pulses a synchronous clear, tracks the far side's pending flag, then acks requesters.
module cdc_clear_sequencer #(
  parameter int NumReq       = 2,
  parameter int DrainTimeout = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] ack_o,
  output logic              busy_o,
  output logic              timeout_o,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  output logic              cdc_valid_o,
  input  logic              cdc_ready_i,
  output logic              cdc_clear_o,
  input  logic              cdc_clear_pending_i
);

  localparam int CntW = $clog2(DrainTimeout + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DrainTimeout - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DrainTimeout);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_DONE
  } state_e;

  // Handshake: a beat moves on cdc_valid_o & cdc_ready_i (equivalently
  // up_valid_i & up_ready_o); the path is a pure pass-through only in IDLE.

  state_e            state_q, state_d;
  logic [NumReq-1:0] served_q, served_d;
  logic [NumReq-1:0] ack_q, ack_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic              timeout_q, timeout_d;
  logic              clear_q, clear_d;

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    served_d  = served_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    ack_d     = '0;
    clear_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d   = ST_DRAIN;
          served_d  = req_i;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_inc;
        if (cdc_ready_i && !cdc_clear_pending_i) begin
          state_d = ST_CLEAR;
          clear_d = 1'b1;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          // A foreign clear still in progress: skip our own pulse and ride on it.
          if (!cdc_clear_pending_i) begin
            state_d = ST_CLEAR;
            clear_d = 1'b1;
          end else begin
            state_d = ST_WAIT_FALL;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_WAIT_RISE;
        cnt_d   = '0;
      end
      ST_WAIT_RISE: begin
        cnt_d = cnt_inc;
        if (cdc_clear_pending_i) begin
          state_d = ST_WAIT_FALL;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
          ack_d     = served_q;
        end
      end
      ST_WAIT_FALL: begin
        if (!cdc_clear_pending_i) begin
          state_d = ST_DONE;
          ack_d   = served_q;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        served_d = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        served_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      served_q  <= '0;
      ack_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      served_q  <= served_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      clear_q   <= clear_d;
    end
  end

  assign ack_o       = ack_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign cdc_valid_o = (state_q == ST_IDLE) & up_valid_i;
  assign up_ready_o  = (state_q == ST_IDLE) & cdc_ready_i;
  // Never drive a clear on top of one the far side is still processing.
  assign cdc_clear_o = clear_q & ~cdc_clear_pending_i;

endmodule

// File: tb/tb_cdc_clear_sequencer.sv
// Bench for cdc_clear_sequencer: per-sequence timelines are derived from drain,
// foreign-clear and pending-rise/fall parameters, then checked every cycle.
module tb_cdc_clear_sequencer;

  localparam int NR = 2;
  localparam int DT = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NR-1:0] req_i;
  logic [NR-1:0] ack_o;
  logic          busy_o;
  logic          timeout_o;
  logic          up_valid_i;
  logic          up_ready_o;
  logic          cdc_valid_o;
  logic          cdc_ready_i;
  logic          cdc_clear_o;
  logic          cdc_clear_pending_i;

  int errors = 0;
  int checks = 0;
  logic prev_to = 1'b0;
  logic valid_hold = 1'b0;

  cdc_clear_sequencer #(.NumReq(NR), .DrainTimeout(DT)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_i(req_i),
    .ack_o(ack_o),
    .busy_o(busy_o),
    .timeout_o(timeout_o),
    .up_valid_i(up_valid_i),
    .up_ready_o(up_ready_o),
    .cdc_valid_o(cdc_valid_o),
    .cdc_ready_i(cdc_ready_i),
    .cdc_clear_o(cdc_clear_o),
    .cdc_clear_pending_i(cdc_clear_pending_i)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_to);
    chk({tag, " busy"}, 32'(busy_o), 32'd0);
    chk({tag, " clear"}, 32'(cdc_clear_o), 32'd0);
    chk({tag, " ack"}, 32'(ack_o), 32'd0);
    chk({tag, " cdc_valid"}, 32'(cdc_valid_o), 32'(up_valid_i));
    chk({tag, " up_ready"}, 32'(up_ready_o), 32'(cdc_ready_i));
    chk({tag, " timeout"}, 32'(timeout_o), 32'(exp_to));
  endtask

  // Idle cycles with no requests; starts and ends 1 time unit after a rising edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_i               = '0;
      up_valid_i          = 1'($urandom_range(0, 1));
      cdc_ready_i         = 1'($urandom_range(0, 1));
      cdc_clear_pending_i = 1'($urandom_range(0, 1));
      #4;
      chk_idle("idle", prev_to);
      @(posedge clk);
      #1;
    end
  endtask

  // One clear sequence. t=0 is the IDLE cycle that first sees the request.
  // ready_at: first DRAIN cycle index with cdc_ready_i high; fp: foreign pending
  // held high over cycles 1..fp; rise_dly: WAIT_RISE cycle index where pending
  // rises (>=DT means never); fall_len: cycles pending stays high.
  task automatic run_seq(input logic [NR-1:0] r, input int ready_at, input int fp,
                         input int rise_dly, input int fall_len,
                         input logic [NR-1:0] early, input int early_t, input int abort_t);
    int e, drain_len, t_clr, t_done, wr0, rise_t, low_t;
    bit drain_to, to_wf, rise_to;
    logic rdy, pend, exp_to;
    string tg;
    e         = (ready_at > fp) ? ready_at : fp;
    drain_to  = (e > DT - 1);
    drain_len = drain_to ? DT : e + 1;
    to_wf     = drain_to && (fp > DT - 1);
    rise_to   = 1'b0;
    t_clr     = -1;
    rise_t    = -1;
    low_t     = -1;
    wr0       = 0;
    if (to_wf) begin
      t_done = fp + 2;
    end else begin
      t_clr = drain_len + 1;
      wr0   = t_clr + 1;
      if (rise_dly <= DT - 1) begin
        rise_t = wr0 + rise_dly;
        low_t  = rise_t + fall_len;
        t_done = low_t + 1;
      end else begin
        rise_to = 1'b1;
        t_done  = wr0 + DT;
      end
    end
    for (int t = 0; t <= t_done; t++) begin
      req_i = r | ((t >= early_t) ? early : '0);
      pend  = (t >= 1 && t <= fp) || (rise_t >= 0 && t >= rise_t && t < low_t);
      if (t >= 1 && t <= drain_len) rdy = (t - 1 >= ready_at);
      else rdy = 1'($urandom_range(0, 1));
      cdc_ready_i         = rdy;
      cdc_clear_pending_i = pend;
      up_valid_i          = valid_hold ? 1'b1 : 1'($urandom_range(0, 1));
      #4;
      tg = $sformatf("seq r=%0b t=%0d", r, t);
      if (t == 0) exp_to = prev_to;
      else exp_to = (drain_to && t >= DT + 1) || (rise_to && t == t_done);
      chk({tg, " busy"}, 32'(busy_o), 32'(t != 0));
      chk({tg, " clear"}, 32'(cdc_clear_o), 32'(t == t_clr));
      chk({tg, " ack"}, 32'(ack_o), (t == t_done) ? 32'(r) : 32'd0);
      chk({tg, " cdc_valid"}, 32'(cdc_valid_o), (t == 0) ? 32'(up_valid_i) : 32'd0);
      chk({tg, " up_ready"}, 32'(up_ready_o), (t == 0) ? 32'(cdc_ready_i) : 32'd0);
      chk({tg, " timeout"}, 32'(timeout_o), 32'(exp_to));
      if (t == abort_t) begin
        #1 rst_i = 1'b1;
        #1;
        prev_to = 1'b0;
        chk_idle("reset abort", 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    prev_to = drain_to || rise_to;
  endtask

  initial begin
    logic [NR-1:0] r, nxt, early;
    rst_i               = 1'b1;
    req_i               = '0;
    up_valid_i          = 1'b0;
    cdc_ready_i         = 1'b0;
    cdc_clear_pending_i = 1'b0;
    @(posedge clk);
    #1;
    up_valid_i  = 1'b1;
    cdc_ready_i = 1'b1;
    req_i       = 2'b11;
    #1;
    chk_idle("reset", 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(2);

    // basic clear, pending rises 2 cycles after the clear pulse, low 5 later
    run_seq(2'b01, 0, 0, 1, 5, '0, 999, -1);
    idle(1);
    // both requesters; requester 1 asks again during WAIT_FALL
    run_seq(2'b11, 2, 0, 0, 6, 2'b10, 8, -1);
    run_seq(2'b10, 0, 0, 3, 2, '0, 999, -1);
    idle(2);
    // ready never arrives: drain timeout
    run_seq(2'b01, 999, 0, 2, 2, '0, 999, -1);
    idle(1);
    // foreign clear pending at DRAIN entry
    run_seq(2'b10, 0, 4, 1, 1, '0, 999, -1);
    idle(1);
    // pending never rises, upstream valid held high
    valid_hold = 1'b1;
    run_seq(2'b01, 1, 0, 999, 1, '0, 999, -1);
    valid_hold = 1'b0;
    idle(1);
    // drain timeout while a foreign clear is still pending
    run_seq(2'b11, 999, 20, 0, 1, '0, 999, -1);
    idle(1);
    // reset in WAIT_FALL, request still held, so a new sequence restarts
    run_seq(2'b01, 0, 0, 1, 8, '0, 999, 6);
    run_seq(2'b01, 0, 0, 0, 2, '0, 999, -1);
    idle(2);

    nxt = '0;
    for (int s = 0; s < 40; s++) begin
      r = (nxt != '0) ? nxt : NR'($urandom_range(1, 3));
      early = $urandom_range(0, 1) ? (NR'($urandom_range(1, 3)) & ~r) : '0;
      run_seq(r, $urandom_range(0, 20),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0,
              $urandom_range(0, 18), $urandom_range(1, 6),
              early, $urandom_range(1, 4), -1);
      nxt = early;
      if (early == '0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
